// File: rtl/pipeline_muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: one operation in flight,
// shift-add multiplier and restoring divider retiring one bit per cycle.
module pipeline_muldiv_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [2:0]            in_unsigned_op,
  input  logic                  in_is_word_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [4:0]            in_dst_reg,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_dst_reg
);

  localparam int W     = DATA_WIDTH;
  localparam int HW    = W / 2;
  localparam int CNT_W = $clog2(W) + 1;

  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_MULH = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_REM  = 4'd9;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [3:0]       op_q;
  logic [2:0]       uns_q;
  logic             word_q;
  logic [W-1:0]     a_q, b_q;
  logic [4:0]       dst_q;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc, mcand;
  logic [W-1:0]     mplier;
  logic [W-1:0]     dvd, dvs, rem, quo;
  logic             neg_res, neg_rem;
  logic [W-1:0]     result;

  logic             accept, op_ok, is_mul, is_div;
  logic             signed_a, signed_b, a_neg, b_neg;
  logic [W-1:0]     a_ext, b_ext, a_mag, b_mag, a_word_sext;
  logic             div_zero, div_ovf, special;
  logic [W-1:0]     special_result;
  logic [W:0]       rem_sh, rem_diff;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix, rem_fix, fix_result;

  assign op_ok  = (in_op >= OP_MUL) && (in_op <= OP_REM);
  assign accept = (state == IDLE) && in_valid && !flush && op_ok;
  assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);
  assign is_div = (op_q == OP_DIV);

  // MULHSU keeps a signed and b unsigned; code 1 makes both unsigned
  assign signed_a    = (uns_q != 3'd1);
  assign signed_b    = (uns_q == 3'd0);
  assign a_word_sext = {{HW{a_q[HW-1]}}, a_q[HW-1:0]};
  assign a_ext = !word_q ? a_q : signed_a ? a_word_sext : {{HW{1'b0}}, a_q[HW-1:0]};
  assign b_ext = !word_q ? b_q :
                 signed_b ? {{HW{b_q[HW-1]}}, b_q[HW-1:0]} : {{HW{1'b0}}, b_q[HW-1:0]};
  assign a_neg = signed_a && a_ext[W-1];
  assign b_neg = signed_b && b_ext[W-1];
  assign a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
  assign b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;

  assign div_zero = (b_ext == '0);
  assign div_ovf  = (uns_q == 3'd0) &&
                    (word_q ? ((a_q[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) && (b_q[HW-1:0] == '1))
                            : ((a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1)));
  assign special  = !is_mul && (div_zero || div_ovf);

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = is_div ? '1 : (word_q ? a_word_sext : a_q);
    else if (div_ovf)
      special_result = is_div ? (word_q ? a_word_sext : a_q) : '0;
  end

  // Restoring step: the remainder never exceeds the divisor, so bit W flags a borrow
  assign rem_sh   = {rem, dvd[W-1]};
  assign rem_diff = rem_sh - {1'b0, dvs};

  assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_res ? (~quo + 1'b1) : quo;
  assign rem_fix  = neg_rem ? (~rem + 1'b1) : rem;

  always_comb begin
    fix_result = '0;
    if (is_mul) begin
      if (word_q)
        fix_result = {{HW{prod_fix[HW-1]}}, prod_fix[HW-1:0]};
      else if (op_q == OP_MULH)
        fix_result = prod_fix[2*W-1:W];
      else
        fix_result = prod_fix[W-1:0];
    end else if (is_div) begin
      fix_result = word_q ? {{HW{quo_fix[HW-1]}}, quo_fix[HW-1:0]} : quo_fix;
    end else begin
      fix_result = word_q ? {{HW{rem_fix[HW-1]}}, rem_fix[HW-1:0]} : rem_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PREP;
      PREP:    state_next = special ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign out_result  = result;
  assign out_dst_reg = dst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      uns_q   <= '0;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            uns_q  <= in_unsigned_op;
            word_q <= in_is_word_op;
            a_q    <= in_a;
            b_q    <= in_b;
            dst_q  <= in_dst_reg;
          end
        end
        PREP: begin
          cnt     <= word_q ? CNT_W'(HW) : CNT_W'(W);
          acc     <= '0;
          mcand   <= {{W{1'b0}}, a_mag};
          mplier  <= b_mag;
          // Word dividends are pre-aligned so the next bit is always the MSB
          dvd     <= word_q ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
          dvs     <= b_mag;
          rem     <= '0;
          quo     <= '0;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          if (special)
            result <= special_result;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_mul) begin
            if (mplier[0])
              acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            dvd <= dvd << 1;
            if (!rem_diff[W]) begin
              rem <= rem_diff[W-1:0];
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= rem_sh[W-1:0];
              quo <= {quo[W-2:0], 1'b0};
            end
          end
        end
        FIX: result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv_seq.sv
// Directed bench for pipeline_muldiv_seq: hand-computed results, latency,
// stall hold, flush, reset and illegal-op behaviour.
module tb_pipeline_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_unsigned_op;
  logic        in_is_word_op;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_dst_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_dst_reg;

  int checks = 0;
  int errors = 0;

  pipeline_muldiv_seq #(.DATA_WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_unsigned_op (in_unsigned_op),
    .in_is_word_op  (in_is_word_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_dst_reg     (in_dst_reg),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_dst_reg    (out_dst_reg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Presents one operation and returns 1 ns into cycle T+1 after the accept edge
  task automatic apply_stimulus(input logic [3:0] op, input logic [2:0] uns,
                                input logic word, input logic [63:0] a,
                                input logic [63:0] b, input logic [4:0] dst);
    @(posedge clk);
    #1;
    in_valid       = 1'b1;
    in_op          = op;
    in_unsigned_op = uns;
    in_is_word_op  = word;
    in_a           = a;
    in_b           = b;
    in_dst_reg     = dst;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] uns,
                        input logic word, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] dst, input logic [63:0] exp_res,
                        input int exp_cycle, input int stall);
    int cycle;
    apply_stimulus(op, uns, word, a, b, dst);
    cycle = 1;
    @(negedge clk);
    while (!out_valid && cycle < 200) begin
      @(negedge clk);
      cycle++;
    end
    check_output({tag, " latency"}, 64'(cycle), 64'(exp_cycle));
    check_output({tag, " result"}, out_result, exp_res);
    check_output({tag, " dst"}, 64'(out_dst_reg), 64'(dst));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output({tag, " stall result"}, out_result, exp_res);
      check_output({tag, " stall in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_output({tag, " in_ready after handshake"}, 64'(in_ready), 64'(1));
    check_output({tag, " out_valid after handshake"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int saw_valid;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_op          = 4'd0;
    in_unsigned_op = 3'd0;
    in_is_word_op  = 1'b0;
    in_a           = 64'd0;
    in_b           = 64'd0;
    in_dst_reg     = 5'd0;
    flush          = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("reset in_ready", 64'(in_ready), 64'(1));
    check_output("reset out_valid", 64'(out_valid), 64'(0));
    check_output("reset out_result", out_result, 64'd0);
    check_output("reset out_dst_reg", 64'(out_dst_reg), 64'(0));

    $display("[TB] arithmetic vectors");
    run_op("MUL 7*-3", 4'd6, 3'd0, 1'b0, 64'd7, -64'sd3, 5'd12, 64'hFFFF_FFFF_FFFF_FFEB, 67, 0);
    run_op("MULH -1*-1", 4'd7, 3'd0, 1'b0, '1, '1, 5'd1, 64'h0, 67, 0);
    run_op("MULHU -1*-1", 4'd7, 3'd1, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
    run_op("MULHSU -1*2", 4'd7, 3'd2, 1'b0, '1, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run_op("MULW 7fffffff*2", 4'd6, 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
    run_op("DIVW -7/2", 4'd8, 3'd0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 35, 0);
    run_op("REMW -7/2", 4'd9, 3'd0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
    run_op("DIV -100/7", 4'd8, 3'd0, 1'b0, -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67, 0);
    run_op("REM -100/7", 4'd9, 3'd0, 1'b0, -64'sd100, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
    run_op("DIVU max/16", 4'd8, 3'd1, 1'b0, '1, 64'd16, 5'd9, 64'h0FFF_FFFF_FFFF_FFFF, 67, 0);

    $display("[TB] divide corner cases");
    run_op("DIV 100/0", 4'd8, 3'd0, 1'b0, 64'd100, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("REM 100/0", 4'd9, 3'd0, 1'b0, 64'd100, 64'd0, 5'd11, 64'd100, 2, 0);
    run_op("DIV ovf", 4'd8, 3'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd13, 64'h8000_0000_0000_0000, 2, 0);
    run_op("REM ovf", 4'd9, 3'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 64'd0, 2, 0);

    $display("[TB] output stall");
    run_op("MUL stall 3*5", 4'd6, 3'd0, 1'b0, 64'd3, 64'd5, 5'd15, 64'd15, 67, 10);

    $display("[TB] flush mid-divide");
    apply_stimulus(4'd8, 3'd0, 1'b0, 64'd1000, 64'd7, 5'd16);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_output("flush in_ready", 64'(in_ready), 64'(1));
    saw_valid = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    check_output("flush no out_valid", 64'(saw_valid), 64'(0));

    $display("[TB] flush with in_valid");
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op    = 4'd6;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check_output("flush+valid in_ready", 64'(in_ready), 64'(1));

    $display("[TB] reset during CALC");
    apply_stimulus(4'd6, 3'd0, 1'b0, 64'd9, 64'd9, 5'd17);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("mid reset in_ready", 64'(in_ready), 64'(1));
    check_output("mid reset out_valid", 64'(out_valid), 64'(0));
    check_output("mid reset out_result", out_result, 64'd0);
    check_output("mid reset out_dst_reg", 64'(out_dst_reg), 64'(0));

    $display("[TB] illegal opcode");
    apply_stimulus(4'd1, 3'd0, 1'b0, 64'd5, 64'd6, 5'd18);
    @(negedge clk);
    check_output("illegal op in_ready", 64'(in_ready), 64'(1));
    saw_valid = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    check_output("illegal op no out_valid", 64'(saw_valid), 64'(0));

    run_op("MUL after aborts", 4'd6, 3'd0, 1'b0, 64'd12, 64'd11, 5'd19, 64'd132, 67, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_muldiv_seq.md
# pipeline_muldiv_seq

Multi-cycle sequencer for the RV64M integer multiply/divide operations (MUL, MULH, DIV, REM and their word/unsigned variants). It sits beside the execute stage: the execute stage hands over M-extension operations, stalls its upstream ready until the result returns, then forwards the result to the memory stage. One operation is in flight at a time. An iterative shift-add multiplier and a restoring divider, one bit per cycle, replace single-cycle 64x64 arithmetic.

## Interface
- DATA_WIDTH, 64: operand/result width; only 64 is supported (word ops use bits [31:0]).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  sequencer can accept; equals (state == IDLE).
- in_op  in  4  6=MUL, 7=MULH, 8=DIV, 9=REM (execute-stage opcode values).
- in_unsigned_op  in  3  0=signed; 1=unsigned (MULHU/DIVU/REMU); 2=MULHSU (MULH only).
- in_is_word_op  in  1  32-bit W variant (MULW/DIVW/DIVUW/REMW/REMUW).
- in_a  in  64  rs1 value.
- in_b  in  64  rs2 value.
- in_dst_reg  in  5  destination register tag, returned unchanged.
- flush  in  1  abort the operation in flight; no result is produced.
- out_valid  out  1  result available.
- out_ready  in  1  consumer (memory-stage side) accepts the result.
- out_result  out  64  final result.
- out_dst_reg  out  5  captured tag.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid with in_op in 6..9, latch operands, op, flags and tag, then go to PREP. In_valid with any other in_op is dropped with no state change.
- PREP: compute the magnitudes of the signed operands and record the result sign. For word ops, use sign- or zero-extended [31:0]. Load iteration counter N = 32 (word) or 64.
  - Divisor == 0: DIV result = all ones; REM result = dividend (word: sign-extended low 32 bits). Go to DONE.
  - Signed overflow (dividend = most negative, divisor = -1, at operand width): DIV result = dividend; REM result = 0. Go to DONE.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; counter decrements; go to FIX when the counter reaches 0.
  - Multiply: 128-bit product register, shift-add on the multiplier LSB.
  - Divide: restoring; the remainder register is shifted left with the next dividend bit; subtract if the result is non-negative; quotient bit shifted in.
- FIX: apply two's-complement negation where required.
  - MUL/MULH: negate if operand signs differ (MULHSU: sign of a only).
  - DIV: quotient negative if signs differ.
  - REM: remainder takes the dividend's sign.
  - Select the result: MUL = product[63:0]; MULH = product[127:64]; word MUL = sign-extended product[31:0]. Word DIV/REM results are sign-extended from bit 31 for both signed and unsigned ops.
  - Go to DONE.
- DONE: out_valid=1; out_result and out_dst_reg held stable. When out_ready=1, go to IDLE.
- flush: in any state the next state is IDLE and out_valid drops; the latched operation is discarded. Flush and in_valid in the same cycle: flush wins and nothing is accepted.
- reset: state=IDLE, counter=0, out_valid=0, out_result=0, out_dst_reg=0, all internal registers 0. in_ready=1 in the first cycle after reset. Reset mid-operation discards the operation.

## Timing
- Accept at clock edge T (in_valid & in_ready):
  - PREP in cycle T+1.
  - CALC in cycles T+2 .. T+N+1.
  - FIX in cycle T+N+2.
  - out_valid=1 from cycle T+N+3.
- Latency to out_valid: 67 cycles (64-bit) or 35 cycles (word). Divide-by-zero and overflow cases: 2 cycles (DONE in T+2).
- The out_valid/out_ready handshake completes on a clock edge where both are 1. in_ready returns to 1 in the following cycle, so there is no back-to-back accept in the same cycle as the result handshake.
- out_result/out_dst_reg do not change while out_valid=1 and out_ready=0 (any length of stall).
- in_ready is combinational from state only and does not depend on in_valid.

## Test plan
- MUL a=7, b=-3 (64-bit) -> out_result=0xFFFFFFFFFFFFFFEB at accept+67; tag 5'd12 returned on out_dst_reg.
- MULH a=-1, b=-1 -> 0. MULHU a=-1, b=-1 -> 0xFFFFFFFFFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFFFFFFFFFF.
- DIVW a=0x00000000_FFFFFFF9 (-7), b=2 -> 0xFFFFFFFFFFFFFFFD at accept+35. REMW on the same operands -> 0xFFFFFFFFFFFFFFFF.
- DIV a=100, b=0 -> all ones at accept+2. REM a=100, b=0 -> 100. DIV a=0x8000000000000000, b=-1 -> 0x8000000000000000; REM on the same operands -> 0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_result stable and in_ready=0 throughout; raise out_ready -> in_ready=1 in the next cycle.
- Assert flush at accept+20 of a DIV -> IDLE next cycle, out_valid never rises. Assert reset during CALC -> all outputs at reset values next cycle. In_valid with in_op=1 -> not accepted, no output.
